shot_resolver: RTL

//  Downstream of the cursor controller. On a debounced fire-button press it latches the

---
 rtl/battleship_pkg.sv | 38 +++
 rtl/shot_resolver_if.sv | 31 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/shot_resolver.sv | 129 ++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types, sizes and cell-index helpers for the battleship datapath.
package battleship_pkg;

  localparam int GRID_SIZE = 10;
  localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int COORD_W   = 4;
  localparam int ADDR_W    = 7;
  localparam int HITS_W    = 5;
  localparam int SHOTS_W   = 7;

  // Two-bit code stored per board cell; 2'b11 is never written.
  typedef enum logic [1:0] {
    CELL_UNKNOWN = 2'b00,
    CELL_MISS    = 2'b01,
    CELL_HIT     = 2'b10
  } cell_state_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_REPEAT  = 3'd3,
    ST_DONE    = 3'd4
  } fsm_state_t;

  // True when both coordinates address a real cell of the grid.
  function automatic logic cell_in_range(input logic [COORD_W-1:0] row,
                                         input logic [COORD_W-1:0] col);
    return (row < COORD_W'(GRID_SIZE)) && (col < COORD_W'(GRID_SIZE));
  endfunction

  // Linear cell index row*GRID_SIZE+col, shared by ship map and shot board.
  function automatic logic [ADDR_W-1:0] cell_idx(input logic [COORD_W-1:0] row,
                                                 input logic [COORD_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(GRID_SIZE) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/shot_resolver_if.sv
// Bundle of the resolver's cursor, ship-map, query and result signals.
interface shot_resolver_if;

  logic       btn_fire;
  logic [3:0] cursor_row;
  logic [3:0] cursor_col;
  logic [6:0] ship_addr;
  logic       ship_data;
  logic [3:0] q_row;
  logic [3:0] q_col;
  logic [1:0] q_state;
  logic       shot_valid;
  logic       shot_hit;
  logic       shot_repeat;
  logic [4:0] hits;
  logic [6:0] shots;
  logic       game_over;

  // View of the resolver itself.
  modport slave (
    input  btn_fire, cursor_row, cursor_col, ship_data, q_row, q_col,
    output ship_addr, q_state, shot_valid, shot_hit, shot_repeat, hits, shots, game_over
  );

  // View of whatever drives the resolver (cursor logic, ship ROM, renderer).
  modport master (
    output btn_fire, cursor_row, cursor_col, ship_data, q_row, q_col,
    input  ship_addr, q_state, shot_valid, shot_hit, shot_repeat, hits, shots, game_over
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: slow sample tick, 3-deep history, rising-edge pulse.
module btn_debounce #(
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic edge_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       hist_q, hist_d;
  logic             prev_q;
  logic             level;

  // Free-running divider; the button is sampled on the cycle it wraps to zero.
  // NOTE: every signal assigned here gets a default first so no latch can be inferred.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    hist_d = hist_q;
    if (&div_q) begin
      hist_d = {hist_q[1:0], btn_i};
    end
  end

  // Level is only trusted once three consecutive samples agree on pressed.
  assign level  = &hist_q;
  assign edge_o = level & ~prev_q;

  // Divider, history and previous-level registers.
  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      hist_q <= '0;
      prev_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      hist_q <= hist_d;
      prev_q <= level;
    end
  end

endmodule

// File: rtl/shot_resolver.sv
// Resolves fire presses against the ship map, keeps the shot board and score.
module shot_resolver
  import battleship_pkg::*;
#(
  parameter int SAMPLE_DIV_W     = 16,
  parameter int TOTAL_SHIP_CELLS = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  shot_resolver_if.slave bus
);

  localparam int BOARD_W = 2 * NUM_CELLS;

  logic               fire_edge;
  fsm_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [HITS_W-1:0]  hits_q, hits_d, hits_inc;
  logic [SHOTS_W-1:0] shots_q, shots_d;
  logic [1:0]         q_state_q, q_state_d;
  logic               shot_valid, shot_hit, shot_repeat;

  logic               cursor_ok;
  logic [ADDR_W-1:0]  cursor_idx;
  logic [1:0]         cursor_cell;
  logic               q_ok;
  logic [ADDR_W-1:0]  q_idx;

  btn_debounce #(
    .DIV_W (SAMPLE_DIV_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.btn_fire),
    .edge_o (fire_edge)
  );

  assign cursor_ok   = cell_in_range(bus.cursor_row, bus.cursor_col);
  assign cursor_idx  = cell_idx(bus.cursor_row, bus.cursor_col);
  assign cursor_cell = board_q[{cursor_idx, 1'b0} +: 2];
  assign q_ok        = cell_in_range(bus.q_row, bus.q_col);
  assign q_idx       = cell_idx(bus.q_row, bus.q_col);
  assign hits_inc    = (&hits_q) ? hits_q : hits_q + HITS_W'(1);

  // Shot FSM: latch the cell, wait for the ROM, then record and score the shot.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    board_d     = board_q;
    hits_d      = hits_q;
    shots_d     = shots_q;
    shot_valid  = 1'b0;
    shot_hit    = 1'b0;
    shot_repeat = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fire_edge) begin
          if (cursor_ok) begin
            // addr_q doubles as the latched cell, so later cursor moves cannot touch it.
            addr_d  = cursor_idx;
            state_d = (cursor_cell == CELL_UNKNOWN) ? ST_LOOKUP : ST_REPEAT;
          end else begin
            state_d = ST_REPEAT;
          end
        end
      end
      ST_LOOKUP: begin
        state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        board_d[{addr_q, 1'b0} +: 2] = bus.ship_data ? CELL_HIT : CELL_MISS;
        shots_d    = (&shots_q) ? shots_q : shots_q + SHOTS_W'(1);
        hits_d     = bus.ship_data ? hits_inc : hits_q;
        shot_valid = 1'b1;
        shot_hit   = bus.ship_data;
        state_d    = (hits_d == HITS_W'(TOTAL_SHIP_CELLS)) ? ST_DONE : ST_IDLE;
      end
      ST_REPEAT: begin
        shot_repeat = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Renderer query: reads the pre-write board, so a same-cycle write shows next cycle.
  always_comb begin
    q_state_d = CELL_UNKNOWN;
    if (q_ok) begin
      q_state_d = board_q[{q_idx, 1'b0} +: 2];
    end
  end

  // FSM, latched cell, board, counters and query register.
  // NOTE: the board is a register array, not RAM, so it must be reset to clear every cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      board_q   <= '0;
      hits_q    <= '0;
      shots_q   <= '0;
      q_state_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      board_q   <= board_d;
      hits_q    <= hits_d;
      shots_q   <= shots_d;
      q_state_q <= q_state_d;
    end
  end

  assign bus.ship_addr   = addr_q;
  assign bus.q_state     = q_state_q;
  assign bus.shot_valid  = shot_valid;
  assign bus.shot_hit    = shot_hit;
  assign bus.shot_repeat = shot_repeat;
  assign bus.hits        = hits_q;
  assign bus.shots       = shots_q;
  assign bus.game_over   = (state_q == ST_DONE);

endmodule
